// File: rtl/wb_mem_arbiter_if.sv
// rtl/wb_mem_arbiter_if.sv - Wishbone classic bus bundle shared by the arbiter's master and slave sides
interface wb_mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [AW-1:0] addr;
  logic [DW-1:0] dat_w;
  logic [3:0]    sel;
  logic          cyc;
  logic          stb;
  logic          we;
  logic [DW-1:0] dat_r;
  logic          ack;
  logic          err;

  modport master (output addr, dat_w, sel, cyc, stb, we, input dat_r, ack, err);
  modport slave  (input addr, dat_w, sel, cyc, stb, we, output dat_r, ack, err);
endinterface

// File: rtl/wb_mem_arbiter.sv
// rtl/wb_mem_arbiter.sv - two-master Wishbone classic arbiter in front of a single bram port
// Optional abort of hung slave cycles is built when ARB_TIMEOUT_EN is defined.
module wb_mem_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int RR_EN_DEF = 1,
  parameter int TIMEOUT   = 16
) (
  input  logic              clk,
  input  logic              rst,
  wb_mem_arbiter_if.slave   i_bus,
  wb_mem_arbiter_if.slave   d_bus,
  wb_mem_arbiter_if.master  s_bus,
  output logic [1:0]        grant_o
`ifdef ARB_TIMEOUT_EN
  ,
  output logic              timeout_o
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  localparam logic LAST_I = 1'b0;
  localparam logic LAST_D = 1'b1;

  state_t        state_q, state_d;
  logic          last_q, last_d;
  logic [1:0]    grant_q, grant_d;

  logic          own_i, own_d;
  logic          live, abort;
  logic [AW-1:0] addr_mux;
  logic [DW-1:0] wdat_mux;
  logic [3:0]    sel_mux;
  logic          cyc_mux, stb_mux, we_mux;

  assign own_i = (state_q == GNT_I);
  assign own_d = (state_q == GNT_D);

  always_comb begin
    addr_mux = '0;
    wdat_mux = '0;
    sel_mux  = '0;
    cyc_mux  = 1'b0;
    stb_mux  = 1'b0;
    we_mux   = 1'b0;
    if (own_i) begin
      addr_mux = i_bus.addr;
      wdat_mux = i_bus.dat_w;
      sel_mux  = i_bus.sel;
      cyc_mux  = i_bus.cyc;
      stb_mux  = i_bus.stb;
      we_mux   = i_bus.we;
    end else if (own_d) begin
      addr_mux = d_bus.addr;
      wdat_mux = d_bus.dat_w;
      sel_mux  = d_bus.sel;
      cyc_mux  = d_bus.cyc;
      stb_mux  = d_bus.stb;
      we_mux   = d_bus.we;
    end
  end

  // Responses only count while the owner is actually strobing, so a slave ack
  // arriving after the owner walked away never reaches either master.
  assign live = cyc_mux & stb_mux;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT + 1) > 5) ? $clog2(TIMEOUT + 1) : 5;

  logic [CW-1:0] cnt_q, cnt_d;

  assign abort = live & ~s_bus.ack & ~s_bus.err & (cnt_q == CW'(TIMEOUT));

  always_comb begin
    cnt_d = cnt_q;
    if (!cyc_mux || s_bus.ack || s_bus.err || abort) begin
      cnt_d = '0;
    end else if (stb_mux) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout_o = abort;
`else
  assign abort = 1'b0;
`endif

  assign s_bus.addr  = addr_mux;
  assign s_bus.dat_w = wdat_mux;
  assign s_bus.sel   = sel_mux;
  assign s_bus.we    = we_mux;
  assign s_bus.cyc   = cyc_mux & ~abort;
  assign s_bus.stb   = stb_mux & ~abort;

  assign i_bus.ack   = own_i & live & s_bus.ack;
  assign i_bus.err   = own_i & ((live & s_bus.err) | abort);
  assign i_bus.dat_r = own_i ? s_bus.dat_r : '0;

  assign d_bus.ack   = own_d & live & s_bus.ack;
  assign d_bus.err   = own_d & ((live & s_bus.err) | abort);
  assign d_bus.dat_r = own_d ? s_bus.dat_r : '0;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (i_bus.cyc && d_bus.cyc) begin
          if (RR_EN_DEF != 0) begin
            state_d = (last_q == LAST_D) ? GNT_I : GNT_D;
          end else begin
            state_d = GNT_D;
          end
        end else if (i_bus.cyc) begin
          state_d = GNT_I;
        end else if (d_bus.cyc) begin
          state_d = GNT_D;
        end
      end
      // Release hands straight over to a waiting master with no idle bubble.
      GNT_I: begin
        if (!i_bus.cyc || abort) begin
          last_d  = LAST_I;
          state_d = d_bus.cyc ? GNT_D : IDLE;
        end
      end
      GNT_D: begin
        if (!d_bus.cyc || abort) begin
          last_d  = LAST_D;
          state_d = i_bus.cyc ? GNT_I : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    grant_d = {state_d == GNT_D, state_d == GNT_I};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      last_q  <= LAST_D;
      grant_q <= 2'b00;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
    end
  end

  assign grant_o = grant_q;

endmodule
